// File: rtl/led_pkg.sv
// Shared types and defaults for the LED chaser: pattern modes, FSM states,
// default step periods and the sweep-length helper.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_LEFT   = 2'b00,
        MODE_RIGHT  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Default step periods in clocks at 50 MHz: 1 s, 100 ms, 10 ms, 1 ms.
    localparam int unsigned T0_DEF = 32'd50_000_000;
    localparam int unsigned T1_DEF = 32'd5_000_000;
    localparam int unsigned T2_DEF = 32'd500_000;
    localparam int unsigned T3_DEF = 32'd50_000;

    // Number of steps taken to return from the start pattern to itself.
    function automatic int unsigned sweep_len(input mode_e m, input int unsigned n_led);
        case (m)
            MODE_LEFT:   return n_led;
            MODE_RIGHT:  return n_led;
            MODE_BOUNCE: return 32'd2 * (n_led - 32'd1);
            MODE_BLINK:  return 32'd2;
            default:     return n_led;
        endcase
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Loadable period counter: counts enabled cycles and flags the last cycle
// of each period. A load clears the count and captures a new period.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int unsigned CNT_W      = 26,
    parameter int unsigned RST_PERIOD = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_period,
    input  logic             i_en,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic             w_last;

    assign w_last = (r_cnt == (r_period - {{(CNT_W-1){1'b0}}, 1'b1}));
    assign o_tick = i_en & w_last;

    // Count enabled cycles, wrapping at period-1; a load restarts the period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_period <= CNT_W'(RST_PERIOD);
        end else if (i_load) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_period <= i_period;
        end else if (i_en) begin
            if (w_last) begin
                r_cnt <= {CNT_W{1'b0}};
            end else begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/led_chaser_mod.sv
// Parametrised LED chaser: four patterns at four step rates. Mode and rate
// are only sampled in the one-cycle load state between sweeps, so a pattern
// never changes shape part-way through a sweep.
module led_chaser_mod
    import led_pkg::*;
#(
    parameter int unsigned N_LED = 4,
    parameter int unsigned CNT_W = 26,
    parameter int unsigned T0    = T0_DEF,
    parameter int unsigned T1    = T1_DEF,
    parameter int unsigned T2    = T2_DEF,
    parameter int unsigned T3    = T3_DEF
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [1:0]       mode,
    input  logic             rate_auto,
    input  logic [1:0]       rate_sel,
    input  logic             pause,
    output logic [N_LED-1:0] LED,
    output logic [1:0]       rate_idx,
    output logic             sweep_done
);

    localparam int unsigned      STEP_W    = $clog2(32'd2 * N_LED);
    localparam longint unsigned  CNT_LIMIT = 64'd1 << CNT_W;

    // Reject parameter sets the counter or pattern logic cannot honour.
    if (N_LED < 32'd2) begin : g_bad_nled
        $error("led_chaser_mod: N_LED must be at least 2");
    end
    if ((T0 < 32'd2) || (T1 < 32'd2) || (T2 < 32'd2) || (T3 < 32'd2)) begin : g_bad_tmin
        $error("led_chaser_mod: every step period must be at least 2");
    end
    if ((64'(T0) >= CNT_LIMIT) || (64'(T1) >= CNT_LIMIT) ||
        (64'(T2) >= CNT_LIMIT) || (64'(T3) >= CNT_LIMIT)) begin : g_bad_tmax
        $error("led_chaser_mod: a step period does not fit in CNT_W bits");
    end

    state_e            r_state;
    mode_e             r_mode;
    logic              r_auto;
    logic [N_LED-1:0]  r_led;
    logic              r_dir_up;
    logic [STEP_W-1:0] r_step;
    logic [1:0]        r_rate;
    logic              r_done;

    logic [1:0]        w_load_idx;
    logic [CNT_W-1:0]  w_period;
    logic              w_load;
    logic              w_en;
    logic              w_tick;
    logic              w_last_step;
    logic [N_LED-1:0]  w_start_pat;
    logic [N_LED-1:0]  w_next_led;
    logic              w_next_dir;

    // In manual mode the load uses the freshly selected index, not the old one.
    assign w_load_idx  = rate_auto ? r_rate : rate_sel;
    assign w_load      = (r_state == ST_LOAD);
    assign w_en        = (r_state == ST_RUN) && !pause;
    assign w_last_step = (r_step == STEP_W'(sweep_len(r_mode, N_LED) - 32'd1));

    // Step period lookup for the rate being loaded.
    always_comb begin
        w_period = CNT_W'(T0);
        case (w_load_idx)
            2'd0:    w_period = CNT_W'(T0);
            2'd1:    w_period = CNT_W'(T1);
            2'd2:    w_period = CNT_W'(T2);
            2'd3:    w_period = CNT_W'(T3);
            default: w_period = CNT_W'(T0);
        endcase
    end

    // Start pattern for the mode about to be latched.
    always_comb begin
        w_start_pat = {{(N_LED-1){1'b0}}, 1'b1};
        case (mode_e'(mode))
            MODE_LEFT:   w_start_pat = {{(N_LED-1){1'b0}}, 1'b1};
            MODE_RIGHT:  w_start_pat = {1'b1, {(N_LED-1){1'b0}}};
            MODE_BOUNCE: w_start_pat = {{(N_LED-1){1'b0}}, 1'b1};
            MODE_BLINK:  w_start_pat = {N_LED{1'b1}};
            default:     w_start_pat = {{(N_LED-1){1'b0}}, 1'b1};
        endcase
    end

    // One pattern step for the latched mode; bounce flips direction at either end.
    always_comb begin
        w_next_led = r_led;
        w_next_dir = r_dir_up;
        case (r_mode)
            MODE_LEFT:  w_next_led = {r_led[N_LED-2:0], r_led[N_LED-1]};
            MODE_RIGHT: w_next_led = {r_led[0], r_led[N_LED-1:1]};
            MODE_BOUNCE: begin
                if (r_dir_up) begin
                    if (r_led[N_LED-1]) begin
                        w_next_led = {1'b0, r_led[N_LED-1:1]};
                        w_next_dir = 1'b0;
                    end else begin
                        w_next_led = {r_led[N_LED-2:0], 1'b0};
                        w_next_dir = 1'b1;
                    end
                end else begin
                    if (r_led[0]) begin
                        w_next_led = {r_led[N_LED-2:0], 1'b0};
                        w_next_dir = 1'b1;
                    end else begin
                        w_next_led = {1'b0, r_led[N_LED-1:1]};
                        w_next_dir = 1'b0;
                    end
                end
            end
            MODE_BLINK: w_next_led = ~r_led;
            default:    w_next_led = r_led;
        endcase
    end

    led_tick_gen #(
        .CNT_W      (CNT_W),
        .RST_PERIOD (T0)
    ) u_tick (
        .i_clk    (CLOCK),
        .i_rst_n  (RESET),
        .i_load   (w_load),
        .i_period (w_period),
        .i_en     (w_en),
        .o_tick   (w_tick)
    );

    // Sweep FSM: load latches mode/rate and the start pattern; run steps on
    // each tick and returns to load on the step that closes the sweep.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= ST_LOAD;
            r_mode   <= MODE_LEFT;
            r_auto   <= 1'b0;
            r_led    <= {N_LED{1'b0}};
            r_dir_up <= 1'b1;
            r_step   <= {STEP_W{1'b0}};
            r_rate   <= 2'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    r_mode   <= mode_e'(mode);
                    r_auto   <= rate_auto;
                    if (!rate_auto) begin
                        r_rate <= rate_sel;
                    end else begin
                        r_rate <= r_rate;
                    end
                    r_led    <= w_start_pat;
                    r_dir_up <= 1'b1;
                    r_step   <= {STEP_W{1'b0}};
                    r_state  <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_tick) begin
                        if (w_last_step) begin
                            // LED holds its final position through the load cycle.
                            r_done  <= 1'b1;
                            if (r_auto) begin
                                r_rate <= r_rate + 2'd1;
                            end else begin
                                r_rate <= r_rate;
                            end
                            r_step  <= {STEP_W{1'b0}};
                            r_state <= ST_LOAD;
                        end else begin
                            r_led    <= w_next_led;
                            r_dir_up <= w_next_dir;
                            r_step   <= r_step + {{(STEP_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign LED        = r_led;
    assign rate_idx   = r_rate;
    assign sweep_done = r_done;

endmodule

// File: tb/tb_led_chaser_mod.sv
// Bench for led_chaser_mod with N_LED=4 and periods {8,4,2,2}. Expected
// positions (pattern, dwell, sweep_done count, rate) are queued from a small
// model of the specified sequences and compared as the DUT walks through them.
module tb_led_chaser_mod;

    localparam int NL = 4;
    localparam int P0 = 8;
    localparam int P1 = 4;
    localparam int P2 = 2;
    localparam int P3 = 2;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          rate_auto = 1'b1;
    logic [1:0]    rate_sel = 2'd0;
    logic          pause = 1'b0;
    logic [NL-1:0] LED;
    logic [1:0]    rate_idx;
    logic          sweep_done;

    typedef struct {
        logic [NL-1:0] val;
        int            dwell;
        int            done;
        logic [1:0]    ridx;
    } pos_t;

    pos_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    led_chaser_mod #(
        .N_LED (NL),
        .CNT_W (8),
        .T0    (P0),
        .T1    (P1),
        .T2    (P2),
        .T3    (P3)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .mode       (mode),
        .rate_auto  (rate_auto),
        .rate_sel   (rate_sel),
        .pause      (pause),
        .LED        (LED),
        .rate_idx   (rate_idx),
        .sweep_done (sweep_done)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic int period_of(input int r);
        case (r)
            0:       return P0;
            1:       return P1;
            2:       return P2;
            default: return P3;
        endcase
    endfunction

    function automatic int exp_len(input int m);
        if (m < 2) return NL;
        else if (m == 2) return 2 * (NL - 1);
        else return 2;
    endfunction

    function automatic logic [NL-1:0] exp_pat(input int m, input int k);
        logic [NL-1:0] one;
        int p;
        one = {{(NL-1){1'b0}}, 1'b1};
        case (m)
            0: return one << k;
            1: return (one << (NL - 1)) >> k;
            2: begin
                p = (k < NL) ? k : (2 * (NL - 1) - k);
                return one << p;
            end
            default: return (k == 0) ? {NL{1'b1}} : {NL{1'b0}};
        endcase
    endfunction

    // Queue every position of one sweep of mode m at rate r.
    task automatic push_sweep(input int m, input int r);
        pos_t e;
        int len;
        len = exp_len(m);
        for (int k = 0; k < len; k++) begin
            e.val   = exp_pat(m, k);
            e.dwell = period_of(r) + ((k == len - 1) ? 1 : 0);
            e.done  = (k == len - 1) ? 1 : 0;
            e.ridx  = 2'(r);
            sb.push_back(e);
        end
    endtask

    // Measure the position showing at this sample: value, samples held,
    // sweep_done pulses seen, rate at its start. Returns on the first sample
    // of the following position.
    task automatic next_pos(output logic [NL-1:0] val, output int dwell,
                            output int done, output logic [1:0] ridx, output bit tmo);
        val   = LED;
        ridx  = rate_idx;
        dwell = 1;
        done  = sweep_done ? 1 : 0;
        tmo   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLOCK);
            if (LED !== val) return;
            dwell++;
            done = done + (sweep_done ? 1 : 0);
        end
        tmo = 1'b1;
    endtask

    task automatic do_reset(input logic [1:0] m, input logic au, input logic [1:0] sel);
        @(negedge CLOCK);
        RESET     = 1'b0;
        mode      = m;
        rate_auto = au;
        rate_sel  = sel;
        pause     = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLOCK);
        n_tests++;
        if (LED !== 4'b0000 || rate_idx !== 2'd0 || sweep_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: led=%b rate=%0d done=%b, want 0000/0/0", LED, rate_idx, sweep_done);
        end
        RESET = 1'b1;
        @(negedge CLOCK);
        n_tests++;
        if (LED !== 4'b0001 || rate_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: led=%b rate=%0d, want 0001/0", LED, rate_idx);
        end
    endtask

    task automatic test_left_auto();
        logic [NL-1:0] v; int dw; int dn; logic [1:0] ri; bit to; pos_t e; int n;
        for (int r = 0; r < 4; r++) push_sweep(0, r);
        n = 0;
        while (sb.size() > 0) begin
            next_pos(v, dw, dn, ri, to);
            e = sb.pop_front();
            n_tests++;
            if (to || v !== e.val || dw != e.dwell || dn != e.done || ri !== e.ridx) begin
                n_fail++;
                $display("FAIL left_auto pos %0d: got led=%b dwell=%0d done=%0d rate=%0d to=%0d, want led=%b dwell=%0d done=%0d rate=%0d",
                         n, v, dw, dn, ri, to, e.val, e.dwell, e.done, e.ridx);
            end
            n++;
        end
        n_tests++;
        if (LED !== 4'b0001 || rate_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL left_auto_wrap: led=%b rate=%0d, want 0001/0", LED, rate_idx);
        end
    endtask

    task automatic test_bounce_then_blink();
        logic [NL-1:0] v; int dw; int dn; logic [1:0] ri; bit to; pos_t e; int n;
        do_reset(2'b10, 1'b0, 2'd1);
        push_sweep(2, 1);
        push_sweep(3, 1);
        n = 0;
        while (sb.size() > 0) begin
            next_pos(v, dw, dn, ri, to);
            e = sb.pop_front();
            n_tests++;
            if (to || v !== e.val || dw != e.dwell || dn != e.done || ri !== e.ridx) begin
                n_fail++;
                $display("FAIL bounce_blink pos %0d: got led=%b dwell=%0d done=%0d rate=%0d to=%0d, want led=%b dwell=%0d done=%0d rate=%0d",
                         n, v, dw, dn, ri, to, e.val, e.dwell, e.done, e.ridx);
            end
            if (n == 0) mode = 2'b11;
            n++;
        end
    endtask

    task automatic test_right();
        logic [NL-1:0] v; int dw; int dn; logic [1:0] ri; bit to; pos_t e; int n;
        do_reset(2'b01, 1'b0, 2'd3);
        push_sweep(1, 3);
        n = 0;
        while (sb.size() > 0) begin
            next_pos(v, dw, dn, ri, to);
            e = sb.pop_front();
            n_tests++;
            if (to || v !== e.val || dw != e.dwell || dn != e.done || ri !== e.ridx) begin
                n_fail++;
                $display("FAIL right pos %0d: got led=%b dwell=%0d done=%0d rate=%0d to=%0d, want led=%b dwell=%0d done=%0d rate=%0d",
                         n, v, dw, dn, ri, to, e.val, e.dwell, e.done, e.ridx);
            end
            n++;
        end
    endtask

    task automatic test_manual_rate();
        logic [NL-1:0] v; int dw; int dn; logic [1:0] ri; bit to; pos_t e; int n;
        do_reset(2'b00, 1'b0, 2'd2);
        push_sweep(0, 2);
        push_sweep(0, 0);
        n = 0;
        while (sb.size() > 0) begin
            next_pos(v, dw, dn, ri, to);
            e = sb.pop_front();
            n_tests++;
            if (to || v !== e.val || dw != e.dwell || dn != e.done || ri !== e.ridx) begin
                n_fail++;
                $display("FAIL manual_rate pos %0d: got led=%b dwell=%0d done=%0d rate=%0d to=%0d, want led=%b dwell=%0d done=%0d rate=%0d",
                         n, v, dw, dn, ri, to, e.val, e.dwell, e.done, e.ridx);
            end
            if (n == 0) rate_sel = 2'd0;
            n++;
        end
    endtask

    task automatic test_pause();
        int dw; int frozen_bad;
        do_reset(2'b00, 1'b0, 2'd0);
        dw = 1;
        repeat (3) begin
            @(negedge CLOCK);
            if (LED === 4'b0001) dw++;
        end
        pause = 1'b1;
        frozen_bad = 0;
        repeat (20) begin
            @(negedge CLOCK);
            if (LED !== 4'b0001) frozen_bad++;
            else dw++;
        end
        pause = 1'b0;
        n_tests++;
        if (frozen_bad != 0) begin
            n_fail++;
            $display("FAIL pause_frozen: %0d samples moved, want 0", frozen_bad);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge CLOCK);
            if (LED !== 4'b0001) break;
            dw++;
        end
        n_tests++;
        if (dw != P0 + 20 || LED !== 4'b0010) begin
            n_fail++;
            $display("FAIL pause_dwell: held %0d then led=%b, want %0d then 0010", dw, LED, P0 + 20);
        end
        repeat (P0 - 1) @(negedge CLOCK);
        pause = 1'b1;
        @(negedge CLOCK);
        n_tests++;
        if (LED !== 4'b0010) begin
            n_fail++;
            $display("FAIL pause_on_wrap: led=%b, want 0010", LED);
        end
        pause = 1'b0;
        @(negedge CLOCK);
        n_tests++;
        if (LED !== 4'b0100) begin
            n_fail++;
            $display("FAIL pause_resume: led=%b, want 0100", LED);
        end
    endtask

    task automatic test_reset_mid();
        logic [NL-1:0] v; int dw; int dn; logic [1:0] ri; bit to; pos_t e; int n;
        do_reset(2'b10, 1'b1, 2'd0);
        push_sweep(2, 0);
        push_sweep(2, 1);
        for (n = 0; n < 8; n++) begin
            next_pos(v, dw, dn, ri, to);
            e = sb.pop_front();
            n_tests++;
            if (to || v !== e.val || dw != e.dwell || dn != e.done || ri !== e.ridx) begin
                n_fail++;
                $display("FAIL reset_mid pos %0d: got led=%b dwell=%0d done=%0d rate=%0d to=%0d, want led=%b dwell=%0d done=%0d rate=%0d",
                         n, v, dw, dn, ri, to, e.val, e.dwell, e.done, e.ridx);
            end
        end
        sb.delete();
        @(negedge CLOCK);
        #2 RESET = 1'b0;
        #1;
        n_tests++;
        if (LED !== 4'b0000 || rate_idx !== 2'd0 || sweep_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: led=%b rate=%0d done=%b, want 0000/0/0", LED, rate_idx, sweep_done);
        end
        @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        next_pos(v, dw, dn, ri, to);
        n_tests++;
        if (to || v !== 4'b0001 || dw != P0 || ri !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_restart: led=%b dwell=%0d rate=%0d, want 0001/%0d/0", v, dw, ri, P0);
        end
    endtask

    task automatic test_blink();
        logic [NL-1:0] v; int dw; int dn; logic [1:0] ri; bit to; pos_t e; int n;
        do_reset(2'b11, 1'b1, 2'd0);
        push_sweep(3, 0);
        push_sweep(3, 1);
        n = 0;
        while (sb.size() > 0) begin
            next_pos(v, dw, dn, ri, to);
            e = sb.pop_front();
            n_tests++;
            if (to || v !== e.val || dw != e.dwell || dn != e.done || ri !== e.ridx) begin
                n_fail++;
                $display("FAIL blink pos %0d: got led=%b dwell=%0d done=%0d rate=%0d to=%0d, want led=%b dwell=%0d done=%0d rate=%0d",
                         n, v, dw, dn, ri, to, e.val, e.dwell, e.done, e.ridx);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_left_auto();
        test_bounce_then_blink();
        test_right();
        test_manual_rate();
        test_pause();
        test_reset_mid();
        test_blink();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
